// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clock_pkg
//  Purpose  : Shared definitions for the HH:MM:SS timekeeper: set-mode state
//             encodings, field_blank bit positions and BCD field limits.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package clock_pkg;

    // Encoding is visible on the set_state output, so the values are fixed.
    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_HOUR = 2'b01,
        ST_SET_MIN  = 2'b10,
        ST_SET_SEC  = 2'b11
    } set_state_t;

    // Bit positions inside field_blank = {hour, min, sec}
    localparam int FB_HOUR = 2;
    localparam int FB_MIN  = 1;
    localparam int FB_SEC  = 0;

    // Highest legal value of each time field
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

endpackage
`default_nettype wire

// File: rtl/bcd_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_mod_counter
//  Purpose  : Two-digit BCD counter that wraps to 00 after reaching the value
//             MOD_TENS:MOD_ONES. The ones digit rolls 9 -> 0 into the tens
//             digit below that limit, so a 23 limit gives 00..23.
//  Ports    : clk    in   system clock
//             reset  in   synchronous active-high reset (clears to 00)
//             inc    in   advance by one
//             clr    in   force to 00 (overrides inc)
//             tens   out  BCD tens digit
//             ones   out  BCD ones digit
//             carry  out  inc while at the limit (combinational)
//  Revision : 1.0  initial release
// ============================================================================
module bcd_mod_counter #(
    parameter int MOD_TENS = 5,
    parameter int MOD_ONES = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       carry
);

    localparam logic [3:0] c_TENS_MAX = 4'(MOD_TENS);
    localparam logic [3:0] c_ONES_MAX = 4'(MOD_ONES);

    logic [3:0] r_tens;
    logic [3:0] r_ones;
    logic       w_at_max;

    assign w_at_max = (r_tens == c_TENS_MAX) && (r_ones == c_ONES_MAX);
    assign carry    = inc & w_at_max;
    assign tens     = r_tens;
    assign ones     = r_ones;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
        end else if (inc) begin
            if (w_at_max) begin
                r_tens <= 4'd0;
                r_ones <= 4'd0;
            end else if (r_ones == 4'd9) begin
                r_tens <= r_tens + 4'd1;
                r_ones <= 4'd0;
            end else begin
                r_ones <= r_ones + 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rtc_timekeeper.sv
`default_nettype none
// ============================================================================
//  Module   : rtc_timekeeper
//  Purpose  : HH:MM:SS timekeeper on a single clock with a 1 Hz clock enable,
//             button-driven time setting, 12/24-hour display formatting and
//             blinking of the field being edited.
//  Ports    : clk, reset            clock / synchronous active-high reset
//             mode_btn, inc_btn     1-cycle button pulses
//             mode_12h              1 = 12-hour display
//             hour/min/sec tens/ones BCD display digits
//             pm                    internal hour >= 12
//             tick_1hz, day_wrap    1-cycle status pulses
//             set_state             00 RUN, 01 hour, 10 min, 11 sec
//             field_blank           {hour,min,sec} blink request
//  Revision : 1.0  initial release
// ============================================================================
module rtc_timekeeper
    import clock_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int BLINK_HZ = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       mode_12h,
    output logic [3:0] hour_tens,
    output logic [3:0] hour_ones,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       pm,
    output logic       tick_1hz,
    output logic       day_wrap,
    output logic [1:0] set_state,
    output logic [2:0] field_blank
);

    localparam int c_PRE_W      = $clog2(CLK_HZ);
    localparam int c_BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
    // +1 keeps the width non-zero when the half period is a single cycle
    localparam int c_BLINK_W    = $clog2(c_BLINK_HALF) + 1;
    localparam logic [c_PRE_W-1:0]   c_PRE_MAX   = c_PRE_W'(CLK_HZ - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_MAX = c_BLINK_W'(c_BLINK_HALF - 1);

    set_state_t           r_state;
    logic [c_PRE_W-1:0]   r_pre;
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                 r_phase;
    logic                 r_tick;
    logic                 r_wrap;

    logic       w_tick;
    logic       w_edit_inc;
    logic       w_sec_carry, w_min_carry, w_hour_carry;
    logic       w_min_inc, w_hour_inc, w_sec_clr;
    logic [3:0] w_h_tens, w_h_ones;
    logic [4:0] w_hour_bin;
    logic [4:0] w_disp_bin;

    // The second boundary: prescaler about to wrap while running
    assign w_tick     = (r_state == ST_RUN) && (r_pre == c_PRE_MAX);
    // A simultaneous mode press takes priority and discards the increment
    assign w_edit_inc = inc_btn & ~mode_btn;

    // w_tick is only ever high in RUN, so edit increments never carry upward
    assign w_min_inc  = (w_tick & w_sec_carry) | (w_edit_inc && r_state == ST_SET_MIN);
    assign w_hour_inc = (w_tick & w_min_carry) | (w_edit_inc && r_state == ST_SET_HOUR);
    assign w_sec_clr  = w_edit_inc && (r_state == ST_SET_SEC);

    bcd_mod_counter #(.MOD_TENS(SEC_MAX / 10), .MOD_ONES(SEC_MAX % 10)) u_sec (
        .clk(clk), .reset(reset), .inc(w_tick), .clr(w_sec_clr),
        .tens(sec_tens), .ones(sec_ones), .carry(w_sec_carry)
    );

    bcd_mod_counter #(.MOD_TENS(MIN_MAX / 10), .MOD_ONES(MIN_MAX % 10)) u_min (
        .clk(clk), .reset(reset), .inc(w_min_inc), .clr(1'b0),
        .tens(min_tens), .ones(min_ones), .carry(w_min_carry)
    );

    bcd_mod_counter #(.MOD_TENS(HOUR_MAX / 10), .MOD_ONES(HOUR_MAX % 10)) u_hour (
        .clk(clk), .reset(reset), .inc(w_hour_inc), .clr(1'b0),
        .tens(w_h_tens), .ones(w_h_ones), .carry(w_hour_carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_pre       <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_tick      <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_tick <= w_tick;
            r_wrap <= w_tick & w_hour_carry;

            // Holding the prescaler at 0 outside RUN makes the first tick after
            // leaving SET_SEC land a full second later.
            if (r_state == ST_RUN && !w_tick) begin
                r_pre <= r_pre + 1'b1;
            end else begin
                r_pre <= '0;
            end

            if (mode_btn) begin
                case (r_state)
                    ST_RUN:      r_state <= ST_SET_HOUR;
                    ST_SET_HOUR: r_state <= ST_SET_MIN;
                    ST_SET_MIN:  r_state <= ST_SET_SEC;
                    default:     r_state <= ST_RUN;
                endcase
                r_blink_cnt <= '0;
                r_phase     <= 1'b0;
            end else if (r_state != ST_RUN) begin
                if (r_blink_cnt == c_BLINK_MAX) begin
                    r_blink_cnt <= '0;
                    r_phase     <= ~r_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
        end
    end

    // Hour display: BCD -> binary, 12h remap, back to BCD (max value 23)
    always_comb begin
        w_hour_bin = 5'(w_h_tens) * 5'd10 + 5'(w_h_ones);
        w_disp_bin = w_hour_bin;
        if (mode_12h) begin
            if (w_hour_bin == 5'd0) begin
                w_disp_bin = 5'd12;
            end else if (w_hour_bin > 5'd12) begin
                w_disp_bin = w_hour_bin - 5'd12;
            end
        end
        if (w_disp_bin >= 5'd20) begin
            hour_tens = 4'd2;
            hour_ones = 4'(w_disp_bin - 5'd20);
        end else if (w_disp_bin >= 5'd10) begin
            hour_tens = 4'd1;
            hour_ones = 4'(w_disp_bin - 5'd10);
        end else begin
            hour_tens = 4'd0;
            hour_ones = 4'(w_disp_bin);
        end
    end

    always_comb begin
        field_blank = 3'b000;
        case (r_state)
            ST_SET_HOUR: field_blank[FB_HOUR] = r_phase;
            ST_SET_MIN:  field_blank[FB_MIN]  = r_phase;
            ST_SET_SEC:  field_blank[FB_SEC]  = r_phase;
            default:     field_blank = 3'b000;
        endcase
    end

    assign pm        = (w_hour_bin >= 5'd12);
    assign tick_1hz  = r_tick;
    assign day_wrap  = r_wrap;
    assign set_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_rtc_timekeeper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rtc_timekeeper
//  Purpose  : Self-checking bench for rtc_timekeeper. A seconds-of-day model
//             with elapsed-cycle counters predicts every output each cycle;
//             directed scenarios are followed by random button traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rtc_timekeeper;

    localparam int CLK_HZ   = 10;
    localparam int BLINK_HZ = 1;
    localparam int HALF     = CLK_HZ / (2 * BLINK_HZ);
    localparam int DAY      = 86400;

    logic       clk = 1'b0;
    logic       reset = 1'b0, mode_btn = 1'b0, inc_btn = 1'b0, mode_12h = 1'b0;
    logic [3:0] hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones;
    logic       pm, tick_1hz, day_wrap;
    logic [1:0] set_state;
    logic [2:0] field_blank;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: time as seconds of day, mode 0..3, cycle counters
    int m_secs = 0, m_mode = 0, m_run_cycles = 0, m_blink_cycles = 0;
    bit m_tick = 0, m_wrap = 0;
    bit g_m12 = 0;

    rtc_timekeeper #(.CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ)) dut (
        .clk(clk), .reset(reset), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .mode_12h(mode_12h),
        .hour_tens(hour_tens), .hour_ones(hour_ones),
        .min_tens(min_tens), .min_ones(min_ones),
        .sec_tens(sec_tens), .sec_ones(sec_ones),
        .pm(pm), .tick_1hz(tick_1hz), .day_wrap(day_wrap),
        .set_state(set_state), .field_blank(field_blank)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] time_now();
        return {hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    // One clock cycle: drive inputs, advance model at the edge, compare at +1.
    task automatic step(input bit r, input bit m, input bit i);
        int h, mi, s, dh;
        logic [23:0] e_time;
        logic [2:0]  e_blank;
        reset = r; mode_btn = m; inc_btn = i; mode_12h = g_m12;
        @(posedge clk);
        if (r) begin
            m_secs = 0; m_mode = 0; m_run_cycles = 0; m_blink_cycles = 0;
            m_tick = 0; m_wrap = 0;
        end else begin
            m_tick = 0; m_wrap = 0;
            if (m_mode == 0) begin
                m_run_cycles++;
                if (m_run_cycles == CLK_HZ) begin
                    m_run_cycles = 0;
                    m_tick = 1;
                    m_wrap = (m_secs == DAY - 1);
                    m_secs = (m_secs + 1) % DAY;
                end
            end
            if (m) begin
                m_mode = (m_mode + 1) % 4;
                m_run_cycles = 0;
                m_blink_cycles = 0;
            end else begin
                h = m_secs / 3600; mi = (m_secs / 60) % 60; s = m_secs % 60;
                if (i && m_mode == 1) h = (h + 1) % 24;
                if (i && m_mode == 2) mi = (mi + 1) % 60;
                if (i && m_mode == 3) s = 0;
                m_secs = h * 3600 + mi * 60 + s;
                if (m_mode != 0) m_blink_cycles++;
            end
        end
        #1;
        h = m_secs / 3600; mi = (m_secs / 60) % 60; s = m_secs % 60;
        dh = g_m12 ? ((h % 12 == 0) ? 12 : h % 12) : h;
        e_time = {4'(dh / 10), 4'(dh % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
        e_blank = (m_mode == 0) ? 3'b000 :
                  (3'(((m_blink_cycles / HALF) % 2)) << (3 - m_mode));
        check("time",  32'(time_now()),  32'(e_time));
        check("pm",    32'(pm),          32'(h >= 12));
        check("tick",  32'(tick_1hz),    32'(m_tick));
        check("wrap",  32'(day_wrap),    32'(m_wrap));
        check("state", 32'(set_state),   32'(m_mode));
        check("blank", 32'(field_blank), 32'(e_blank));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0);
    endtask

    task automatic press_mode();
        step(0, 1, 0);
    endtask

    task automatic press_inc(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 1);
    endtask

    initial begin
        // 1: first ticks after reset
        step(1, 0, 0);
        step(1, 0, 0);
        for (int c = 1; c <= 20; c++) begin
            step(0, 0, 0);
            if (c == 9)  check("t1_no_tick9", 32'(tick_1hz), 32'd0);
            if (c == 10) begin
                check("t1_tick10", 32'(tick_1hz), 32'd1);
                check("t1_time10", 32'(time_now()), 32'h000001);
            end
            if (c == 20) check("t1_time20", 32'(time_now()), 32'h000002);
        end

        // 2: set 23:59:00, run to the day wrap
        press_mode(); press_inc(23);
        press_mode(); press_inc(59);
        press_mode(); press_inc(1);
        press_mode();
        idle(59 * CLK_HZ);
        check("t2_235959", 32'(time_now()), 32'h235959);
        for (int k = 1; k <= CLK_HZ + 1; k++) begin
            step(0, 0, 0);
            if (k == CLK_HZ) begin
                check("t2_wrap", 32'(day_wrap), 32'd1);
                check("t2_midnight", 32'(time_now()), 32'h000000);
            end
            if (k == CLK_HZ + 1) check("t2_wrap_pulse", 32'(day_wrap), 32'd0);
        end

        // 3: 12-hour formatting
        step(1, 0, 0);
        g_m12 = 1;
        step(0, 0, 0);
        check("t3_h00_12h", 32'({hour_tens, hour_ones, 3'b0, pm}), 32'h120);
        press_mode(); press_inc(12);
        check("t3_h12_12h", 32'({hour_tens, hour_ones, 3'b0, pm}), 32'h121);
        press_inc(1);
        check("t3_h13_12h", 32'({hour_tens, hour_ones, 3'b0, pm}), 32'h011);
        g_m12 = 0;
        step(0, 0, 0);
        check("t3_h13_24h", 32'({hour_tens, hour_ones}), 32'h13);

        // 4: hour wrap in SET_HOUR, frozen time, mode beats inc
        press_inc(10);
        check("t4_h23", 32'({hour_tens, hour_ones}), 32'h23);
        press_inc(1);
        check("t4_h00", 32'(time_now()), 32'h000000);
        idle(50);
        check("t4_frozen", 32'(time_now()), 32'h000000);
        step(0, 1, 1);
        check("t4_state_min", 32'(set_state), 32'd2);
        check("t4_min_kept", 32'(time_now()), 32'h000000);

        // 5: reset during SET_MIN at 05:37:12
        step(1, 0, 0);
        press_mode(); press_inc(5);
        press_mode(); press_inc(37);
        press_mode(); press_inc(1);
        press_mode();
        idle(12 * CLK_HZ);
        check("t5_053712", 32'(time_now()), 32'h053712);
        press_mode(); press_mode();
        step(1, 0, 0);
        check("t5_rst", 32'({time_now(), 2'b0, set_state, 1'b0, field_blank, 3'b0, tick_1hz}),
              32'h0);

        // 6: blink timing on SET_HOUR entry, seconds clear in SET_SEC
        idle(3 * CLK_HZ);
        press_mode();
        for (int k = 0; k < 2 * HALF; k++) begin
            if (k > 0) step(0, 0, 0);
            check("t6_blank", 32'(field_blank), (k < HALF) ? 32'd0 : 32'd4);
        end
        press_mode(); press_mode();
        press_inc(1);
        check("t6_sec_clr", 32'({sec_tens, sec_ones}), 32'h00);
        press_mode();

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 99) == 0) g_m12 = ~g_m12;
            step($urandom_range(0, 599) == 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 3) == 0);
        end

        reset = 0; mode_btn = 0; inc_btn = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
